pixel_write_sink: RTL
=====================

Name: pixel_write_sink

Overview:
- Receiving end of the pixel-write stream emitted by the drawing FSMs: X/Y coordinates, 12-bit colour, a write-enable strobe and a done pulse.
- Buffers the pixels in a small FIFO and clips any that fall off-screen.
- Converts coordinates to linear framebuffer addresses and writes to the framebuffer port under a valid/ready handshake.
- When a draw operation finishes, reports a flush-complete pulse once every accepted pixel has been committed to memory.

Parameters:
- SCREEN_W, 320, visible width; pixels with inX >= SCREEN_W are clipped.
- SCREEN_H, 240, visible height; pixels with inY >= SCREEN_H are clipped.
- FIFO_DEPTH, 8, number of FIFO entries; must be a power of 2, range 2..64.
- ADDR_W, 17, framebuffer address width; must satisfy 2^ADDR_W >= SCREEN_W*SCREEN_H.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- inX  in  9  pixel X from drawer.
- inY  in  8  pixel Y from drawer.
- inColor  in  12  pixel colour, RGB 4:4:4.
- writeEn  in  1  pixel valid; sampled every cycle, no backpressure to the drawer.
- drawDone  in  1  one-cycle pulse marking the end of a draw operation.
- full  out  1  FIFO holds FIFO_DEPTH entries (registered).
- memAddr  out  ADDR_W  framebuffer address, equal to inY*SCREEN_W + inX.
- memData  out  12  colour to write.
- memWe  out  1  write request valid.
- memReady  in  1  framebuffer accepts the request.
- flushDone  out  1  one-cycle pulse; the draw operation's pixels are all committed.
- dropCount  out  16  saturating count of pixels lost to overflow.
- clipCount  out  16  saturating count of off-screen pixels discarded.

Behaviour:
- Reset: all outputs go to 0, the FIFO is emptied, drawDone-pending is cleared, and the FSM enters S_IDLE.
- Reset mid-operation discards buffered pixels; no flushDone is issued for that operation.
- Input stage, each cycle with writeEn=1:
  - Off-screen pixel (inX >= SCREEN_W or inY >= SCREEN_H): discarded, clipCount += 1.
  - Else if full=1: discarded, dropCount += 1. full is the registered value, so a pop in the same cycle does not rescue the pixel.
  - Else: {inX, inY, inColor} is pushed into the FIFO.
- Counters saturate at 16'hFFFF.
- Output register (memAddr, memData, memWe) forms a one-entry stage after the FIFO:
  - It loads from the FIFO head when empty, or when the current request completes (memWe & memReady) and the FIFO is non-empty.
  - Address is computed as y*SCREEN_W + x, full-width, then truncated to ADDR_W.
  - memAddr and memData stay stable while memWe=1 and memReady=0.
  - Back-to-back transfers are allowed: one per cycle while memReady=1.
- Latency: with FIFO empty and memReady=1, a pixel sampled at edge t drives memWe=1 in the cycle after edge t+1. Its transfer completes at edge t+2.
- FSM:
  - S_IDLE: no accepted pixels outstanding. A pixel push moves to S_WRITE; drawDone moves to S_FLUSH.
  - S_WRITE: pixels are streaming. drawDone moves to S_FLUSH.
  - S_FLUSH: accepting new pixels is still allowed. When the FIFO is empty and memWe=0, move to S_DONE.
  - S_DONE: flushDone=1 for exactly one cycle, then move to S_IDLE.
- drawDone and writeEn in the same cycle: that pixel belongs to the operation being flushed.
- drawDone while in S_FLUSH or S_DONE is ignored; there is no queuing of done pulses.
- drawDone with nothing outstanding: flushDone is pulsed 2 cycles later (S_FLUSH, then S_DONE).
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth; count is log2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro PIXEL_SINK_DEDUP_EN.
- Defined: a valid on-screen pixel whose {inX, inY, inColor} equals the last pushed pixel is discarded. It counts toward neither counter. This absorbs repeated points from short rope lines.
  - The last-pushed register resets to an invalid state.
  - It is cleared when flushDone pulses, so duplicates are only suppressed within one operation.
- Not defined: every valid on-screen pixel is pushed subject to full; no comparison register exists.

Test Plan:
- Single pixel (inX=10, inY=5, inColor=12'hBBB), memReady=1 -> one transfer with memAddr=1610 and memData=12'hBBB, memWe high in the cycle after edge t+1 (transfer completes at edge t+2).
- inX=320, inY=5 -> no memWe; clipCount=1. inX=319, inY=239 -> memAddr=76799.
- memReady=0 while 12 consecutive valid pixels arrive (depth 8) -> full=1; the FIFO holds 8 pixels and the output register holds 1; dropCount=3. After memReady=1, exactly 9 transfers occur in push order.
- Push 4 pixels with memReady toggling 1/0, then pulse drawDone -> flushDone pulses exactly once, the cycle after the 4th transfer completes.
- Reset asserted while the FIFO holds 3 pixels and S_FLUSH is active -> next cycle all outputs are 0, no flushDone, counters are 0.
- With PIXEL_SINK_DEDUP_EN: the same pixel (20,20,12'hFFF) sent 5 consecutive cycles -> 1 transfer. Without the macro -> 5 transfers.

Source files
------------

// File: rtl/pixel_write_sink.sv
// Pixel-write sink: FIFO-buffered, clipped pixel stream to a valid/ready framebuffer port.
// Optional build macro PIXEL_SINK_DEDUP_EN drops consecutive identical pixels within one operation.
module pixel_write_sink #(
  parameter int SCREEN_W   = 320,
  parameter int SCREEN_H   = 240,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 17
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [8:0]        inX,
  input  logic [7:0]        inY,
  input  logic [11:0]       inColor,
  input  logic              writeEn,
  input  logic              drawDone,
  output logic              full,
  output logic [ADDR_W-1:0] memAddr,
  output logic [11:0]       memData,
  output logic              memWe,
  input  logic              memReady,
  output logic              flushDone,
  output logic [15:0]       dropCount,
  output logic [15:0]       clipCount
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [8:0]  x;
    logic [7:0]  y;
    logic [11:0] color;
  } pixel_t;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FLUSH, S_DONE} state_t;

  pixel_t             fifo_mem [FIFO_DEPTH];
  pixel_t             in_pix;
  pixel_t             head_pix;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic               on_screen;
  logic               is_dup;
  logic               push;
  logic               clip;
  logic               drop;
  logic               pop;
  logic               mem_we_next;
  state_t             state;

`ifdef PIXEL_SINK_DEDUP_EN
  pixel_t last_pix;
  logic   last_valid;
`endif

  // NOTE: every signal written here gets a value on every path, so no latch can be inferred.
  always_comb begin
    in_pix    = '{x: inX, y: inY, color: inColor};
    head_pix  = fifo_mem[rd_ptr];
    on_screen = (32'(inX) < SCREEN_W) && (32'(inY) < SCREEN_H);
`ifdef PIXEL_SINK_DEDUP_EN
    is_dup    = last_valid && (last_pix == in_pix);
`else
    is_dup    = 1'b0;
`endif
    clip        = writeEn && !on_screen;
    push        = writeEn && on_screen && !is_dup && !full;
    drop        = writeEn && on_screen && !is_dup && full;
    // The output stage refills when idle or when its current request is handshaken this cycle.
    pop         = (count != '0) && (!memWe || memReady);
    count_next  = count + CNT_W'(push) - CNT_W'(pop);
    mem_we_next = pop || (memWe && !memReady);
  end

  // NOTE: the pixel storage carries no reset; validity is tracked by the pointers and count alone.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= in_pix;
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      memAddr   <= '0;
      memData   <= '0;
      memWe     <= 1'b0;
      flushDone <= 1'b0;
      dropCount <= '0;
      clipCount <= '0;
      state     <= S_IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == CNT_W'(FIFO_DEPTH));
      memWe <= mem_we_next;
      if (pop) begin
        memAddr <= ADDR_W'(32'(head_pix.y) * 32'(SCREEN_W) + 32'(head_pix.x));
        memData <= head_pix.color;
      end
      if (clip && clipCount != 16'hFFFF) clipCount <= clipCount + 1'b1;
      if (drop && dropCount != 16'hFFFF) dropCount <= dropCount + 1'b1;

      flushDone <= 1'b0;
      case (state)
        S_IDLE: begin
          if (drawDone)  state <= S_FLUSH;
          else if (push) state <= S_WRITE;
        end
        S_WRITE: begin
          if (drawDone) state <= S_FLUSH;
        end
        S_FLUSH: begin
          // Finish as soon as the edge leaves both the FIFO and the output stage empty.
          if (count_next == '0 && !mem_we_next) begin
            state     <= S_DONE;
            flushDone <= 1'b1;
          end
        end
        S_DONE: begin
          state <= push ? S_WRITE : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PIXEL_SINK_DEDUP_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      last_valid <= 1'b0;
      last_pix   <= '0;
    end else if (push) begin
      last_valid <= 1'b1;
      last_pix   <= in_pix;
    end else if (flushDone) begin
      last_valid <= 1'b0;
    end
  end
`endif

endmodule
